// File: rtl/mac_pkg.sv
// Q8.8 constants, types and the activation helper used by mac and its downstream stages.
package mac_pkg;

    localparam int          Q_FRAC_BITS = 8;
    localparam logic [15:0] Q_ONE       = 16'h0100;
    localparam logic [15:0] RELU6_MAX   = 16'h0600;

    typedef logic signed [15:0] q88_t;

    // Negative values go to zero; positive values above clamp_max are limited when clamping is on.
    function automatic q88_t relu_clamp(input q88_t x, input logic clamp_en, input logic [15:0] clamp_max);
        q88_t y;
        y = x;
        if (x[15])
            y = '0;
        else if (clamp_en && ($unsigned(x) > clamp_max))
            y = q88_t'(clamp_max);
        return y;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO with drop detection.
// Latency: a write is visible on rd_data the cycle after it is accepted.
// Backpressure: a write while full is accepted only together with a read; otherwise it is dropped and flagged.
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Status comes only from the registered count, so no input reaches these outputs combinationally.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rd_vld = !empty;
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    assign pop  = rd_vld && rd_rdy;
    assign push = wr_vld && (!full || pop);
    assign drop = wr_vld && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/mac_act_buffer.sv
// Applies ReLU/ReLU6 to each mac result and queues it for the next layer.
// Latency: one cycle from done to out_valid/out_data.
// Backpressure: holds up to DEPTH results; a done while full without a pop is dropped and sets sticky overflow.
module mac_act_buffer
    import mac_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter bit          CLAMP_EN  = 1'b1,
    parameter logic [15:0] CLAMP_MAX = RELU6_MAX
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       done,
    input  logic [15:0]                mac_out,
    output logic [15:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    q88_t act_dat;
    logic drop;

    assign act_dat = relu_clamp(q88_t'(mac_out), CLAMP_EN, CLAMP_MAX);

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (done),
        .wr_dat (act_dat),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (out_data),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .drop   (drop)
    );

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

endmodule
